// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth significand multiplier.
package fp_mul_pkg;

  localparam int MAN_W  = 24;
  localparam int NDIG   = (MAN_W + 2) / 2;
  localparam int PROD_W = 2 * MAN_W;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

  typedef struct packed {
    logic       sign;
    logic [9:0] exp_sum;
    logic [2:0] r_mode;
  } mul_tag_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  // Overlapping 3-bit group {b(2i+1), b(2i), b(2i-1)} to its radix-4 digit.
  function automatic booth_digit_t booth_recode(input logic [2:0] grp);
    booth_digit_t d;
    case (grp)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fp_mul_booth_seq_if.sv
// Operand/result handshake bundle between the unpacker, the multiplier and normalisation.
interface fp_mul_booth_seq_if #(
  parameter int MAN_W = 24,
  parameter int TAG_W = 14
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MAN_W-1:0]     man_X;
  logic [MAN_W-1:0]     man_Y;
  logic [TAG_W-1:0]     tag_in;
  logic                 kill;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*MAN_W-1:0]   frc_Z_full;
  logic                 norm_n;
  logic [TAG_W-1:0]     tag_out;

  modport master (
    output in_valid, man_X, man_Y, tag_in, kill, out_ready,
    input  in_ready, out_valid, frc_Z_full, norm_n, tag_out
  );

  modport slave (
    input  in_valid, man_X, man_Y, tag_in, kill, out_ready,
    output in_ready, out_valid, frc_Z_full, norm_n, tag_out
  );
endinterface

// File: rtl/fp_booth_pp.sv
// Radix-4 Booth recoder: one 3-bit multiplier group times man_x as a signed partial product.
module fp_booth_pp #(
  parameter int MAN_W = 24
) (
  input  logic [2:0]              grp,
  input  logic [MAN_W-1:0]        man_x,
  output logic signed [MAN_W+1:0] pp
);
  import fp_mul_pkg::*;

  booth_digit_t            dig;
  logic signed [MAN_W+1:0] x1;
  logic signed [MAN_W+1:0] x2;

  assign dig = booth_recode(grp);
  assign x1  = $signed({2'b00, man_x});
  assign x2  = x1 <<< 1;

  always_comb begin
    pp = '0;
    case (dig)
      P1:      pp = x1;
      P2:      pp = x2;
      M1:      pp = -x1;
      M2:      pp = -x2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier: one digit per clock, zero early-out, tag sideband.
module fp_mul_booth_seq #(
  parameter int MAN_W = 24,
  parameter int TAG_W = 14
) (
  input logic               clk,
  input logic               rst_n,
  fp_mul_booth_seq_if.slave bus
);
  import fp_mul_pkg::*;

  localparam int ND = (MAN_W + 2) / 2;
  localparam int PW = 2 * MAN_W;
  localparam int AW = PW + 2;
  localparam int EW = MAN_W + 3;
  localparam int CW = $clog2(ND);

  mul_state_t              state, state_nxt;
  logic [CW-1:0]           cnt;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    acc_nxt;
  logic signed [AW-1:0]    pp_sh;
  logic signed [MAN_W+1:0] pp;
  logic [MAN_W-1:0]        x_r;
  logic [EW-1:0]           e_r;
  logic [2:0]              grp;
  logic [PW-1:0]           prod_r;
  logic [TAG_W-1:0]        tag_r;
  logic                    accept;
  logic                    zero_op;
  logic                    last_dig;

  assign bus.in_ready = !bus.kill && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign zero_op      = (bus.man_X == '0) || (bus.man_Y == '0);
  assign last_dig     = (cnt == CW'(ND - 1));

  // Digit i looks at E[2i+2:2i]; E carries an appended 0 below the LSB.
  assign grp = 3'(e_r >> {cnt, 1'b0});

  fp_booth_pp #(.MAN_W(MAN_W)) u_pp (
    .grp   (grp),
    .man_x (x_r),
    .pp    (pp)
  );

  assign pp_sh   = $signed({{(AW - MAN_W - 2){pp[MAN_W+1]}}, pp}) <<< {cnt, 1'b0};
  assign acc_nxt = acc + pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? DONE : BUSY;
      BUSY: if (last_dig) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = zero_op ? DONE : BUSY;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.kill) state_nxt = IDLE;
  end

  // Operand capture on handshake, then one Booth digit accumulated per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      x_r    <= '0;
      e_r    <= '0;
      prod_r <= '0;
      tag_r  <= '0;
    end else if (accept) begin
      x_r   <= bus.man_X;
      e_r   <= {2'b00, bus.man_Y, 1'b0};
      tag_r <= bus.tag_in;
      acc   <= '0;
      cnt   <= '0;
      if (zero_op) prod_r <= '0;
    end else if (state == BUSY && !bus.kill) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last_dig) prod_r <= acc_nxt[PW-1:0];
    end
  end

  assign bus.out_valid  = (state == DONE);
  assign bus.frc_Z_full = prod_r;
  assign bus.norm_n     = prod_r[PW-1];
  assign bus.tag_out    = tag_r;

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Bench for fp_mul_booth_seq: directed vectors, handshake corner cases and a randomized sweep.
module tb_fp_mul_booth_seq;

  localparam int MAN_W = 24;
  localparam int TAG_W = 14;
  localparam int PW    = 2 * MAN_W;
  localparam int LAT   = (MAN_W + 2) / 2 + 1;
  localparam int NVEC  = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_booth_seq_if #(.MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fp_mul_booth_seq #(.MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MAN_W-1:0] x;
    logic [MAN_W-1:0] y;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    prod;
    logic             norm;
    int               lat;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    bus.man_X     = v.x;
    bus.man_Y     = v.y;
    bus.tag_in    = v.tag;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.man_X    = 24'($urandom);
    bus.man_Y    = 24'($urandom);
    bus.tag_in   = 14'($urandom);
    wait_valid(lat);
    check({nm, " latency"}, 64'(lat), 64'(v.lat));
    check({nm, " frc_Z_full"}, 64'(bus.frc_Z_full), 64'(v.prod));
    check({nm, " norm_n"}, 64'(bus.norm_n), 64'(v.norm));
    check({nm, " tag_out"}, 64'(bus.tag_out), 64'(v.tag));
  endtask

  function automatic logic [MAN_W-1:0] rand_man();
    int r;
    r = $urandom_range(9);
    if (r == 0)      return '0;
    else if (r == 1) return 24'($urandom);
    else             return {1'b1, 23'($urandom)};
  endfunction

  initial begin
    int lat;
    logic seen;
    logic             pend_v;
    int               pend_age, pend_lat;
    logic [PW-1:0]    pend_prod;
    logic [TAG_W-1:0] pend_tag, seq;
    logic             exp_ov, exp_rdy;
    int               acc_n, del_n, kill_n;

    vecs[0] = '{x:24'h800000, y:24'h800000, tag:14'h1234, prod:48'h4000_0000_0000, norm:1'b0, lat:LAT};
    vecs[1] = '{x:24'hFFFFFF, y:24'hFFFFFF, tag:14'h2345, prod:48'hFFFF_FE00_0001, norm:1'b1, lat:LAT};
    vecs[2] = '{x:24'h000000, y:24'hC90FDB, tag:14'h0777, prod:48'h0,             norm:1'b0, lat:1};
    vecs[3] = '{x:24'hC00000, y:24'hC00000, tag:14'h3FFF, prod:48'h9000_0000_0000, norm:1'b1, lat:LAT};
    vecs[4] = '{x:24'hABCDEF, y:24'h000000, tag:14'h0001, prod:48'h0,             norm:1'b0, lat:1};
    vecs[5] = '{x:24'h800001, y:24'hFFFFFF, tag:14'h2AAA, prod:48'h8000_007F_FFFF, norm:1'b1, lat:LAT};
    vecs[6] = '{x:24'h000001, y:24'h000001, tag:14'h0F0F, prod:48'h1,             norm:1'b0, lat:LAT};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b1;
    bus.man_X     = '0;
    bus.man_Y     = '0;
    bus.tag_in    = '0;

    @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst frc_Z_full", 64'(bus.frc_Z_full), 64'd0);
    check("rst norm_n", 64'(bus.norm_n), 64'd0);
    check("rst tag_out", 64'(bus.tag_out), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure, then a back-to-back accept on the release cycle.
    @(negedge clk);
    bus.man_X = 24'hC00000; bus.man_Y = 24'hC00000; bus.tag_in = 14'h2ABC;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", 64'(lat), 64'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp hold frc", 64'(bus.frc_Z_full), 64'h9000_0000_0000);
      check("bp hold valid", 64'(bus.out_valid), 64'd1);
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
      check("bp hold tag", 64'(bus.tag_out), 64'h2ABC);
    end
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.man_X = 24'h800000; bus.man_Y = 24'hC00000; bus.tag_in = 14'h0155;
    #1 check("b2b in_ready", 64'(bus.in_ready), 64'd1);
    check("b2b frc delivered", 64'(bus.frc_Z_full), 64'h9000_0000_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("b2b busy valid", 64'(bus.out_valid), 64'd0);
    check("b2b busy ready", 64'(bus.in_ready), 64'd0);
    wait_valid(lat);
    check("b2b latency", 64'(lat), 64'(LAT));
    check("b2b frc", 64'(bus.frc_Z_full), 64'h6000_0000_0000);
    check("b2b norm", 64'(bus.norm_n), 64'd0);
    check("b2b tag", 64'(bus.tag_out), 64'h0155);

    // Kill at BUSY cycle 6, with a competing in_valid in the same cycle.
    @(negedge clk);
    bus.man_X = 24'hFFFFFF; bus.man_Y = 24'hFFFFFF; bus.tag_in = 14'h3333; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.kill = 1'b1; bus.in_valid = 1'b1; bus.man_X = 24'h800000; bus.man_Y = 24'h800000;
    #1 check("kill in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.kill = 1'b0; bus.in_valid = 1'b0;
    #1 check("kill idle ready", 64'(bus.in_ready), 64'd1);
    check("kill out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("kill no result", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a BUSY period.
    @(negedge clk);
    bus.man_X = 24'hABCDEF; bus.man_Y = 24'h123457; bus.tag_in = 14'h1FFF; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", 64'(bus.out_valid), 64'd0);
    check("arst frc", 64'(bus.frc_Z_full), 64'd0);
    check("arst norm", 64'(bus.norm_n), 64'd0);
    check("arst tag", 64'(bus.tag_out), 64'd0);
    check("arst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("arst no result", 64'(bus.out_valid), 64'd0);

    // Randomized sweep against a transaction-level model.
    pend_v = 1'b0; pend_age = 0; pend_lat = 0; pend_prod = '0; pend_tag = '0;
    seq = '0; acc_n = 0; del_n = 0; kill_n = 0;
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (pend_v) pend_age++;
      exp_ov = pend_v && (pend_age >= pend_lat);
      check("sw out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (bus.out_valid && exp_ov) begin
        check("sw frc", 64'(bus.frc_Z_full), 64'(pend_prod));
        check("sw norm", 64'(bus.norm_n), 64'(pend_prod[PW-1]));
        check("sw tag", 64'(bus.tag_out), 64'(pend_tag));
      end
      bus.kill      = ($urandom_range(99) < 2);
      bus.out_ready = ($urandom_range(99) < 70);
      bus.in_valid  = ($urandom_range(99) < 60);
      bus.man_X     = rand_man();
      bus.man_Y     = rand_man();
      bus.tag_in    = seq;
      exp_rdy = !bus.kill && (!pend_v || (exp_ov && bus.out_ready));
      #1 check("sw in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      if (bus.kill) begin
        if (pend_v) kill_n++;
        pend_v = 1'b0;
      end else begin
        if (exp_ov && bus.out_ready) begin
          del_n++;
          pend_v = 1'b0;
        end
        if (bus.in_valid && exp_rdy) begin
          pend_v    = 1'b1;
          pend_age  = 0;
          pend_prod = PW'(bus.man_X) * PW'(bus.man_Y);
          pend_lat  = (bus.man_X == '0 || bus.man_Y == '0) ? 1 : LAT;
          pend_tag  = seq;
          seq       = seq + 14'd1;
          acc_n++;
        end
      end
    end
    check("sw conservation", 64'(acc_n), 64'(del_n + kill_n + int'(pend_v)));
    check("sw deliveries", 64'(del_n > 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
